// File: rtl/pipein_pkg.sv
// pipein_pkg: shared word width, default block size and framing FSM states for pipein_block_rx
package pipein_pkg;
  localparam int WORD_W = 32;
  localparam int DEF_BLOCK_SIZE = 128;
  typedef enum logic {IDLE, IN_BLOCK} state_t;
endpackage

// File: rtl/pipein_fifo_mem.sv
// pipein_fifo_mem: simple dual-port DEPTHxW memory with registered read for block RAM inference
module pipein_fifo_mem #(
  parameter int DEPTH = 1024,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/pipein_block_rx.sv
// pipein_block_rx: block-throttled pipe-in receive FIFO; status counters and framing FSM built only when PIPEIN_STATUS_EN is defined
module pipein_block_rx
  import pipein_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ep_write,
  input  logic              ep_blockstrobe,
  input  logic [WORD_W-1:0] ep_dataout,
  output logic              ep_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  fill_count,
  output logic [31:0]       words_rx,
  output logic              overflow,
  output logic              block_err,
  input  logic              clr_status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] fill_q, fill_d, mcnt_q, mcnt_d;
  logic rv_q, rv_d, mv_q, mv_d, rdy_q, rdy_d;
  logic [WORD_W-1:0] md_q, md_d, rdata;
  logic full, wr_ok, hs, mv_free, rd_en;
  pipein_fifo_mem #(.DEPTH(FIFO_DEPTH), .W(WORD_W), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wptr_q),
    .wdata(ep_dataout),
    .re(rd_en),
    .raddr(rptr_q),
    .rdata(rdata)
  );
  always_comb begin
    full = fill_q == CNT_W'(FIFO_DEPTH);
    wr_ok = ep_write & ~full;
    hs = mv_q & m_ready;
    mv_free = ~mv_q | hs;
    rd_en = (mcnt_q != '0) & (~rv_q | mv_free);
    wptr_d = wptr_q + AW'(wr_ok);
    rptr_d = rptr_q + AW'(rd_en);
    fill_d = fill_q + CNT_W'(wr_ok) - CNT_W'(hs);
    mcnt_d = mcnt_q + CNT_W'(wr_ok) - CNT_W'(rd_en);
    rv_d = rd_en | (rv_q & ~mv_free);
    mv_d = mv_free ? rv_q : mv_q;
    md_d = (mv_free & rv_q) ? rdata : md_q;
    rdy_d = fill_d <= CNT_W'(FIFO_DEPTH - BLOCK_SIZE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      mcnt_q <= '0;
      rv_q <= 1'b0;
      mv_q <= 1'b0;
      md_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      mcnt_q <= mcnt_d;
      rv_q <= rv_d;
      mv_q <= mv_d;
      md_q <= md_d;
      rdy_q <= rdy_d;
    end
  end
  assign ep_ready = rdy_q;
  assign m_data = md_q;
  assign m_valid = mv_q;
  assign fill_count = fill_q;
`ifdef PIPEIN_STATUS_EN
  localparam int WC_W = $clog2(BLOCK_SIZE + 1);
  state_t st_q, st_d, st_e;
  logic [WC_W-1:0] wcnt_q, wcnt_d, wc_e;
  logic [31:0] wrx_q, wrx_d;
  logic ovf_q, ovf_d, berr_q, berr_d, err_set, last;
  always_comb begin
    st_e = ep_blockstrobe ? IN_BLOCK : st_q;
    wc_e = ep_blockstrobe ? '0 : wcnt_q;
    last = wc_e == WC_W'(BLOCK_SIZE - 1);
    err_set = (ep_blockstrobe & (st_q == IN_BLOCK) & (wcnt_q != '0)) | (ep_write & (st_e == IDLE));
    st_d = (ep_write & (st_e == IN_BLOCK) & last) ? IDLE : st_e;
    wcnt_d = (ep_write & (st_e == IN_BLOCK)) ? (last ? '0 : wc_e + WC_W'(1)) : wc_e;
    wrx_d = clr_status ? '0 : wrx_q + 32'(wr_ok & ~&wrx_q);
    ovf_d = ~clr_status & (ovf_q | (ep_write & full));
    berr_d = ~clr_status & (berr_q | err_set);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      wcnt_q <= '0;
      wrx_q <= '0;
      ovf_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wcnt_q <= wcnt_d;
      wrx_q <= wrx_d;
      ovf_q <= ovf_d;
      berr_q <= berr_d;
    end
  end
  assign words_rx = wrx_q;
  assign overflow = ovf_q;
  assign block_err = berr_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, ep_blockstrobe, clr_status};
  assign words_rx = '0;
  assign overflow = 1'b0;
  assign block_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipein_block_rx.sv
// tb_pipein_block_rx: directed self-checking bench for pipein_block_rx
module tb_pipein_block_rx;
`ifdef PIPEIN_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ep_write = 1'b0;
  logic ep_blockstrobe = 1'b0;
  logic [31:0] ep_dataout = '0;
  logic ep_ready;
  logic [31:0] m_data;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [10:0] fill_count;
  logic [31:0] words_rx;
  logic overflow;
  logic block_err;
  logic clr_status = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int mfill = 0;
  int nout = 0;
  int n0;
  logic [31:0] q[$];
  pipein_block_rx dut (
    .clk(clk),
    .rst(rst),
    .ep_write(ep_write),
    .ep_blockstrobe(ep_blockstrobe),
    .ep_dataout(ep_dataout),
    .ep_ready(ep_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fill_count(fill_count),
    .words_rx(words_rx),
    .overflow(overflow),
    .block_err(block_err),
    .clr_status(clr_status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit w, input bit s, input logic [31:0] d);
    logic h;
    logic [31:0] od, e;
    bit st;
    ep_write = w;
    ep_blockstrobe = s;
    ep_dataout = d;
    h = m_valid & m_ready;
    od = m_data;
    st = w && !rst && mfill < 1024;
    if (st) q.push_back(d);
    @(posedge clk);
    #1;
    ep_write = 1'b0;
    ep_blockstrobe = 1'b0;
    if (!rst) mfill += int'(st) - int'(h);
    if (h) begin
      e = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
      chk("m_data", od, e);
      nout++;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask
  initial begin
    idle(2);
    chk("rst_ep_ready", 32'(ep_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_fill", 32'(fill_count), 0);
    chk("rst_words_rx", words_rx, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_block_err", 32'(block_err), 0);
    rst = 1'b0;
    idle(1);
    chk("ep_ready_after_rst", 32'(ep_ready), 1);
    m_ready = 1'b1;
    step(1'b1, 1'b1, 32'h1000);
    chk("lat_edge_n", 32'(m_valid), 0);
    step(1'b1, 1'b0, 32'h1001);
    chk("lat_edge_n1", 32'(m_valid), 0);
    step(1'b1, 1'b0, 32'h1002);
    chk("lat_edge_n2_valid", 32'(m_valid), 1);
    chk("lat_edge_n2_data", m_data, 32'h1000);
    for (int i = 3; i < 128; i++) begin
      step(1'b1, 1'b0, 32'h1000 + 32'(i));
      if (i == 63) chk("stream_fill", 32'(fill_count), 3);
    end
    idle(6);
    chk("blk1_nout", 32'(nout), 128);
    chk("blk1_words_rx", words_rx, ST ? 32'd128 : 32'd0);
    chk("blk1_block_err", 32'(block_err), 0);
    chk("blk1_overflow", 32'(overflow), 0);
    chk("blk1_fill", 32'(fill_count), 0);
    m_ready = 1'b0;
    for (int i = 0; i < 896; i++) step(1'b1, (i % 128) == 0, 32'h2000_0000 + 32'(i));
    chk("fill_896", 32'(fill_count), 896);
    chk("ep_ready_896", 32'(ep_ready), 1);
    step(1'b1, 1'b1, 32'h2000_0000 + 32'd896);
    chk("fill_897", 32'(fill_count), 897);
    chk("ep_ready_897", 32'(ep_ready), 0);
    chk("m_data_held", m_data, 32'h2000_0000);
    for (int i = 897; i < 1024; i++) step(1'b1, 1'b0, 32'h2000_0000 + 32'(i));
    chk("fill_full", 32'(fill_count), 1024);
    chk("ep_ready_full", 32'(ep_ready), 0);
    chk("words_rx_1152", words_rx, ST ? 32'd1152 : 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hBAD0_0000 + 32'(i));
    chk("ovf_flag", 32'(overflow), 32'(ST));
    chk("ovf_fill", 32'(fill_count), 1024);
    chk("ovf_idle_write_err", 32'(block_err), 32'(ST));
    chk("ovf_words_rx", words_rx, ST ? 32'd1152 : 32'd0);
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_block_err", 32'(block_err), 0);
    chk("clr_words_rx", words_rx, 0);
    n0 = nout;
    m_ready = 1'b1;
    idle(1030);
    chk("drain_count", 32'(nout - n0), 1024);
    chk("drain_left", 32'(q.size()), 0);
    chk("drain_fill", 32'(fill_count), 0);
    step(1'b1, 1'b1, 32'hC000);
    for (int i = 1; i < 50; i++) step(1'b1, 1'b0, 32'hC000 + 32'(i));
    chk("short_blk_no_err", 32'(block_err), 0);
    step(1'b0, 1'b1, '0);
    chk("short_blk_err", 32'(block_err), 32'(ST));
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 32'hC100 + 32'(i));
    chk("err_sticky", 32'(block_err), 32'(ST));
    clr_status = 1'b1;
    step(1'b1, 1'b0, 32'hC0FF);
    clr_status = 1'b0;
    chk("clr_prio_err", 32'(block_err), 0);
    chk("clr_prio_words", words_rx, 0);
    chk("clr_prio_ovf", 32'(overflow), 0);
    idle(6);
    n0 = nout;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, (i % 128) == 0, 32'hA000_0000 + 32'(i));
      if (i == 500 || i == 1500) chk("wrap_fill", 32'(fill_count), 3);
    end
    idle(6);
    chk("wrap_count", 32'(nout - n0), 2000);
    chk("wrap_fill_end", 32'(fill_count), 0);
    chk("wrap_block_err", 32'(block_err), 0);
    m_ready = 1'b0;
    step(1'b1, 1'b1, 32'hD000);
    for (int i = 1; i < 60; i++) step(1'b1, 1'b0, 32'hD000 + 32'(i));
    chk("pre_rst_fill", 32'(fill_count), 60);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_fill", 32'(fill_count), 0);
    rst = 1'b0;
    q.delete();
    mfill = 0;
    idle(1);
    m_ready = 1'b1;
    n0 = nout;
    step(1'b1, 1'b1, 32'hB000);
    for (int i = 1; i < 128; i++) step(1'b1, 1'b0, 32'hB000 + 32'(i));
    idle(6);
    chk("post_rst_count", 32'(nout - n0), 128);
    chk("post_rst_words_rx", words_rx, ST ? 32'd128 : 32'd0);
    chk("post_rst_block_err", 32'(block_err), 0);
    chk("post_rst_overflow", 32'(overflow), 0);
    chk("post_rst_fill", 32'(fill_count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
